// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared types and default timing for the VGA display path.
//   - rgb_t        : packed {r,g,b} pixel, 8 bits per colour (24 bits total)
//   - DEF_*        : 640x480@60 timing (pixel clock ~25.175 MHz)
//   - axis_total() : total period of one axis (display + porches + sync)
// ---------------------------------------------------------------------------
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Horizontal timing, in pixel clocks.
  localparam int DEF_HDISP  = 640;
  localparam int DEF_HFP    = 16;
  localparam int DEF_HPULSE = 96;
  localparam int DEF_HBP    = 48;

  // Vertical timing, in lines.
  localparam int DEF_VDISP  = 480;
  localparam int DEF_VFP    = 10;
  localparam int DEF_VPULSE = 2;
  localparam int DEF_VBP    = 33;

  // Length of one full axis period: active area, front porch, sync, back porch.
  function automatic int axis_total(input int disp, input int fp,
                                    input int pulse, input int bp);
    return disp + fp + pulse + bp;
  endfunction

endpackage : vga_pkg

// File: rtl/vga_axis_cnt.sv
// ---------------------------------------------------------------------------
// vga_axis_cnt
//   One timing axis (horizontal or vertical). Counts 0..TOTAL-1 while en is
//   high and decodes the active and sync regions from the current count.
//   Region order along the axis: active, front porch, sync, back porch.
//
// Ports
//   clk     in   1   pixel clock
//   rst     in   1   synchronous reset, active high (count -> 0)
//   en      in   1   advance the count this cycle
//   cnt     out  W   current position on the axis
//   wrap    out  1   en is high and cnt is at TOTAL-1 (count returns to 0)
//   active  out  1   cnt in [0, DISP)
//   sync    out  1   cnt in [DISP+FP, DISP+FP+PULSE)
// ---------------------------------------------------------------------------
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter  int DISP  = DEF_HDISP,
  parameter  int FP    = DEF_HFP,
  parameter  int PULSE = DEF_HPULSE,
  parameter  int BP    = DEF_HBP,
  localparam int TOTAL = axis_total(DISP, FP, PULSE, BP),
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  // All region boundaries fit in W bits because every one is <= TOTAL-1.
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] DISP_END   = W'(DISP);
  localparam logic [W-1:0] SYNC_START = W'(DISP + FP);
  localparam logic [W-1:0] SYNC_END   = W'(DISP + FP + PULSE);

  assign wrap   = en && (cnt == LAST);
  assign active = (cnt < DISP_END);
  assign sync   = (cnt >= SYNC_START) && (cnt < SYNC_END);

  // NOTE: state registers use non-blocking assignment so every flop in the
  // design samples the pre-edge value of its inputs, independent of the
  // order in which always_ff blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule : vga_axis_cnt

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Video timing generator. Two cascaded axis counters produce the pixel
//   position; the position is offered to the upstream pixel source together
//   with a request strobe, and the returned pixel is registered so that it
//   leaves aligned with HS/VS/DE.
//
//   Pipeline:
//     stage 0 : counters; X/Y/REQ/SOF are combinational decodes of them
//     stage 1 : hs/vs/de decodes registered; source drives vga_PIX here
//     stage 2 : output registers HS/VS/DE/RGB
//   X/Y/REQ of a given cycle and the matching HS/VS/DE/RGB are 2 cycles apart.
//
// Ports
//   vga_CLK  in   1    pixel clock
//   vga_RST  in   1    synchronous reset, active high; aborts the frame
//   vga_X    out  XW   current column, to pixel source
//   vga_Y    out  YW   current line, to pixel source
//   vga_REQ  out  1    (X,Y) in active area; pixel expected next cycle
//   vga_SOF  out  1    single-cycle pulse at X==0 && Y==0
//   vga_PIX  in   24   {R,G,B} from source, valid 1 cycle after vga_REQ
//   vga_HS   out  1    horizontal sync, active low
//   vga_VS   out  1    vertical sync, active low
//   vga_DE   out  1    data enable, active high
//   vga_RGB  out  24   output pixel, forced to 0 outside the active area
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter  int HDISP  = DEF_HDISP,
  parameter  int HFP    = DEF_HFP,
  parameter  int HPULSE = DEF_HPULSE,
  parameter  int HBP    = DEF_HBP,
  parameter  int VDISP  = DEF_VDISP,
  parameter  int VFP    = DEF_VFP,
  parameter  int VPULSE = DEF_VPULSE,
  parameter  int VBP    = DEF_VBP,
  localparam int HTOTAL = axis_total(HDISP, HFP, HPULSE, HBP),
  localparam int VTOTAL = axis_total(VDISP, VFP, VPULSE, VBP),
  localparam int XW     = $clog2(HTOTAL),
  localparam int YW     = $clog2(VTOTAL)
) (
  input  logic          vga_CLK,
  input  logic          vga_RST,
  output logic [XW-1:0] vga_X,
  output logic [YW-1:0] vga_Y,
  output logic          vga_REQ,
  output logic          vga_SOF,
  input  logic [23:0]   vga_PIX,
  output logic          vga_HS,
  output logic          vga_VS,
  output logic          vga_DE,
  output logic [23:0]   vga_RGB
);

  // ---------------- stage 0: counters ----------------
  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  logic          h_wrap;
  logic          h_active;
  logic          h_sync;
  logic          v_active;
  logic          v_sync;
  // The end-of-frame wrap has no consumer: SOF is decoded from the counters.
  logic          v_wrap_unused;

  vga_axis_cnt #(
    .DISP  (HDISP),
    .FP    (HFP),
    .PULSE (HPULSE),
    .BP    (HBP)
  ) u_hcnt (
    .clk    (vga_CLK),
    .rst    (vga_RST),
    .en     (1'b1),
    .cnt    (hcnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  // The line counter advances once per line, on the horizontal wrap.
  vga_axis_cnt #(
    .DISP  (VDISP),
    .FP    (VFP),
    .PULSE (VPULSE),
    .BP    (VBP)
  ) u_vcnt (
    .clk    (vga_CLK),
    .rst    (vga_RST),
    .en     (h_wrap),
    .cnt    (vcnt),
    .wrap   (v_wrap_unused),
    .active (v_active),
    .sync   (v_sync)
  );

  assign vga_X   = hcnt;
  assign vga_Y   = vcnt;
  assign vga_REQ = h_active && v_active;
  assign vga_SOF = (hcnt == '0) && (vcnt == '0);

  // ---------------- stages 1 and 2 ----------------
  logic s1_hs;
  logic s1_vs;
  logic s1_de;
  rgb_t pix_in;
  rgb_t rgb_q;

  assign pix_in  = vga_PIX;
  assign vga_RGB = rgb_q;

  // NOTE: every pipeline register is reset, not just the counters, so a
  // reset mid-frame flushes in-flight sync/DE state and no stale pixel can
  // reach the pins after reset is released.
  always_ff @(posedge vga_CLK) begin
    if (vga_RST) begin
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s1_de  <= 1'b0;
      vga_HS <= 1'b1;
      vga_VS <= 1'b1;
      vga_DE <= 1'b0;
      rgb_q  <= '0;
    end else begin
      s1_hs  <= ~h_sync;
      s1_vs  <= ~v_sync;
      s1_de  <= vga_REQ;
      vga_HS <= s1_hs;
      vga_VS <= s1_vs;
      vga_DE <= s1_de;
      // The source answers the stage-0 request during stage 1, so the pixel
      // on vga_PIX now belongs to s1_de; blank it outside the active area.
      rgb_q  <= s1_de ? pix_in : '0;
    end
  end

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three instances share one clock:
//     0 "big"   : default 640x480 timing
//     1 "mid"   : default horizontal timing, short frame (4/2/2/3 lines)
//     2 "small" : 4/1/1/1 x 3/1/1/1 (HTOTAL=7, VTOTAL=6)
//   A per-instance reference counter and pixel source run on the falling
//   edge; expected outputs are queued two cycles ahead and compared when
//   the DUT produces them. Feature tasks measure line/frame timing.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int N = 3;
  localparam int HD [N] = '{640, 640, 4};
  localparam int HF [N] = '{16, 16, 1};
  localparam int HP [N] = '{96, 96, 1};
  localparam int HB [N] = '{48, 48, 1};
  localparam int VD [N] = '{480, 4, 3};
  localparam int VF [N] = '{10, 2, 1};
  localparam int VP [N] = '{2, 2, 1};
  localparam int VB [N] = '{33, 3, 1};

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    rgb_t rgb;
  } exp_t;

  localparam exp_t RST_EXP = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: '0};

  logic          clk;
  logic [N-1:0]  rst_v;
  logic [23:0]   pix_v [N];
  logic [N-1:0]  req_v, sof_v, hs_v, vs_v, de_v;
  logic [23:0]   rgb_v [N];
  logic [9:0]    b_x, b_y, m_x;
  logic [3:0]    m_y;
  logic [2:0]    s_x, s_y;
  logic [31:0]   dx [N];
  logic [31:0]   dy [N];

  int checks = 0;
  int errors = 0;

  // Scoreboard and reference state, owned by the falling-edge process.
  exp_t exp_q [N][$];
  int   rx [N];
  int   ry [N];
  int   px [N];
  int   py [N];
  logic prev_req [N];

  vga_timing_gen #(
    .HDISP(HD[0]), .HFP(HF[0]), .HPULSE(HP[0]), .HBP(HB[0]),
    .VDISP(VD[0]), .VFP(VF[0]), .VPULSE(VP[0]), .VBP(VB[0])
  ) u_big (
    .vga_CLK(clk), .vga_RST(rst_v[0]), .vga_X(b_x), .vga_Y(b_y),
    .vga_REQ(req_v[0]), .vga_SOF(sof_v[0]), .vga_PIX(pix_v[0]),
    .vga_HS(hs_v[0]), .vga_VS(vs_v[0]), .vga_DE(de_v[0]), .vga_RGB(rgb_v[0])
  );

  vga_timing_gen #(
    .HDISP(HD[1]), .HFP(HF[1]), .HPULSE(HP[1]), .HBP(HB[1]),
    .VDISP(VD[1]), .VFP(VF[1]), .VPULSE(VP[1]), .VBP(VB[1])
  ) u_mid (
    .vga_CLK(clk), .vga_RST(rst_v[1]), .vga_X(m_x), .vga_Y(m_y),
    .vga_REQ(req_v[1]), .vga_SOF(sof_v[1]), .vga_PIX(pix_v[1]),
    .vga_HS(hs_v[1]), .vga_VS(vs_v[1]), .vga_DE(de_v[1]), .vga_RGB(rgb_v[1])
  );

  vga_timing_gen #(
    .HDISP(HD[2]), .HFP(HF[2]), .HPULSE(HP[2]), .HBP(HB[2]),
    .VDISP(VD[2]), .VFP(VF[2]), .VPULSE(VP[2]), .VBP(VB[2])
  ) u_small (
    .vga_CLK(clk), .vga_RST(rst_v[2]), .vga_X(s_x), .vga_Y(s_y),
    .vga_REQ(req_v[2]), .vga_SOF(sof_v[2]), .vga_PIX(pix_v[2]),
    .vga_HS(hs_v[2]), .vga_VS(vs_v[2]), .vga_DE(de_v[2]), .vga_RGB(rgb_v[2])
  );

  always_comb begin
    dx[0] = 32'(b_x);
    dy[0] = 32'(b_y);
    dx[1] = 32'(m_x);
    dy[1] = 32'(m_y);
    dx[2] = 32'(s_x);
    dy[2] = 32'(s_y);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int htot(input int k);
    return HD[k] + HF[k] + HP[k] + HB[k];
  endfunction

  function automatic int vtot(input int k);
    return VD[k] + VF[k] + VP[k] + VB[k];
  endfunction

  function automatic rgb_t pix_model(input int x, input int y);
    logic [31:0] xv;
    logic [31:0] yv;
    rgb_t        p;
    xv  = x;
    yv  = y;
    p.r = xv[7:0];
    p.g = yv[7:0];
    p.b = 8'hA5;
    return p;
  endfunction

  function automatic exp_t expect_out(input int k, input int x, input int y);
    exp_t e;
    e.hs  = !((x >= HD[k] + HF[k]) && (x < HD[k] + HF[k] + HP[k]));
    e.vs  = !((y >= VD[k] + VF[k]) && (y < VD[k] + VF[k] + VP[k]));
    e.de  = (x < HD[k]) && (y < VD[k]);
    e.rgb = e.de ? pix_model(x, y) : '0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One falling-edge step for instance k: compare, source a pixel, predict.
  task automatic monitor_step(input int k);
    exp_t e;
    exp_t got;
    logic exp_req;
    logic exp_sof;
    exp_req = (rx[k] < HD[k]) && (ry[k] < VD[k]);
    exp_sof = (rx[k] == 0) && (ry[k] == 0);

    checks++;
    if (dx[k] !== 32'(rx[k]) || dy[k] !== 32'(ry[k])) begin
      errors++;
      $display("FAIL coord[%0d] t=%0t: got X=%0d Y=%0d, expected X=%0d Y=%0d",
               k, $time, dx[k], dy[k], rx[k], ry[k]);
    end
    checks++;
    if (req_v[k] !== exp_req || sof_v[k] !== exp_sof) begin
      errors++;
      $display("FAIL req_sof[%0d] t=%0t: got REQ=%b SOF=%b, expected REQ=%b SOF=%b",
               k, $time, req_v[k], sof_v[k], exp_req, exp_sof);
    end

    got.hs  = hs_v[k];
    got.vs  = vs_v[k];
    got.de  = de_v[k];
    got.rgb = rgb_v[k];
    checks++;
    if (exp_q[k].size() == 0) begin
      errors++;
      $display("FAIL scoreboard[%0d] t=%0t: no expected entry", k, $time);
    end else begin
      e = exp_q[k].pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL outputs[%0d] t=%0t: got HS=%b VS=%b DE=%b RGB=%h, expected HS=%b VS=%b DE=%b RGB=%h",
                 k, $time, got.hs, got.vs, got.de, got.rgb, e.hs, e.vs, e.de, e.rgb);
      end
    end

    // Pixel source: answers last cycle's request; junk when not requested.
    pix_v[k]    = prev_req[k] ? pix_model(px[k], py[k]) : 24'hFFFFFF;
    prev_req[k] = exp_req;
    px[k]       = rx[k];
    py[k]       = ry[k];

    if (rst_v[k]) begin
      exp_q[k].delete();
      exp_q[k].push_back(RST_EXP);
      exp_q[k].push_back(RST_EXP);
      rx[k] = 0;
      ry[k] = 0;
    end else begin
      exp_q[k].push_back(expect_out(k, rx[k], ry[k]));
      if (rx[k] == htot(k) - 1) begin
        rx[k] = 0;
        ry[k] = (ry[k] == vtot(k) - 1) ? 0 : ry[k] + 1;
      end else begin
        rx[k] = rx[k] + 1;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      pix_v[k]    = '0;
      prev_req[k] = 1'b0;
      rx[k] = 0;
      ry[k] = 0;
      px[k] = 0;
      py[k] = 0;
      exp_q[k].push_back(RST_EXP);
      exp_q[k].push_back(RST_EXP);
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) monitor_step(k);
    end
  end

  // ---------------- feature tests ----------------
  task automatic test_reset();
    rst_v = '1;
    repeat (5) tick();
    checks++;
    if ({hs_v[0], vs_v[0], de_v[0]} !== 3'b110 || rgb_v[0] !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got HS=%b VS=%b DE=%b RGB=%h, expected 1 1 0 000000",
               hs_v[0], vs_v[0], de_v[0], rgb_v[0]);
    end
    rst_v = '0;
    checks++;
    if (dx[0] !== 0 || dy[0] !== 0 || req_v[0] !== 1'b1 || sof_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_cycle: got X=%0d Y=%0d REQ=%b SOF=%b, expected 0 0 1 1",
               dx[0], dy[0], req_v[0], sof_v[0]);
    end
    tick();
    checks++;
    if (dx[0] !== 1 || sof_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_second_cycle: got X=%0d SOF=%b, expected 1 0", dx[0], sof_v[0]);
    end
  endtask

  task automatic test_line_timing(input string tag);
    logic prev_de;
    logic prev_hs;
    bit   found;
    int   de_len, hs_fall1, hs_fall2, hs_rise;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      prev_de = de_v[0];
      tick();
      if (de_v[0] && !prev_de) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s de_rise: DE never rose within 3000 cycles", tag);
      return;
    end
    de_len = -1; hs_fall1 = -1; hs_fall2 = -1; hs_rise = -1;
    for (int n = 1; n <= 1700 && hs_fall2 < 0; n++) begin
      prev_de = de_v[0];
      prev_hs = hs_v[0];
      tick();
      if (de_len < 0 && !de_v[0]) de_len = n;
      if (!hs_v[0] && prev_hs) begin
        if (hs_fall1 < 0) hs_fall1 = n;
        else              hs_fall2 = n;
      end
      if (hs_v[0] && !prev_hs && hs_fall1 >= 0 && hs_rise < 0) hs_rise = n;
    end
    checks++;
    if (de_len != 640) begin
      errors++;
      $display("FAIL %s de_width: got %0d, expected 640", tag, de_len);
    end
    checks++;
    if (hs_fall1 != 656) begin
      errors++;
      $display("FAIL %s de_to_hs_fall: got %0d, expected 656", tag, hs_fall1);
    end
    checks++;
    if (hs_rise - hs_fall1 != 96 || hs_rise < 0) begin
      errors++;
      $display("FAIL %s hs_low: got %0d, expected 96", tag, hs_rise - hs_fall1);
    end
    checks++;
    if (hs_fall2 - hs_fall1 != 800 || hs_fall2 < 0) begin
      errors++;
      $display("FAIL %s hs_period: got %0d, expected 800", tag, hs_fall2 - hs_fall1);
    end
  endtask

  task automatic test_frame_timing(input int k, input string tag);
    int   period, low_exp, de_exp, rise, fall, sofs, des;
    logic prev;
    bit   found;
    period  = htot(k) * vtot(k);
    low_exp = VP[k] * htot(k);
    de_exp  = HD[k] * VD[k];
    found   = 0;
    for (int i = 0; i < 2 * period + 10 && !found; i++) begin
      prev = vs_v[k];
      tick();
      if (!vs_v[k] && prev) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s vs_fall: VS never fell within %0d cycles", tag, 2 * period + 10);
      return;
    end
    rise = -1; fall = -1; sofs = 0; des = 0;
    for (int n = 1; n <= period + 10 && fall < 0; n++) begin
      prev = vs_v[k];
      tick();
      if (sof_v[k]) sofs++;
      if (de_v[k])  des++;
      if (vs_v[k] && !prev && rise < 0) rise = n;
      if (!vs_v[k] && prev) fall = n;
    end
    checks++;
    if (fall != period) begin
      errors++;
      $display("FAIL %s vs_period: got %0d, expected %0d", tag, fall, period);
    end
    checks++;
    if (rise != low_exp) begin
      errors++;
      $display("FAIL %s vs_low: got %0d, expected %0d", tag, rise, low_exp);
    end
    checks++;
    if (sofs != 1) begin
      errors++;
      $display("FAIL %s sof_per_frame: got %0d, expected 1", tag, sofs);
    end
    checks++;
    if (des != de_exp) begin
      errors++;
      $display("FAIL %s de_per_frame: got %0d, expected %0d", tag, des, de_exp);
    end
  endtask

  task automatic test_small_params();
    bit   found;
    int   j;
    exp_t e;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (sof_v[2]) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL small_sof: no SOF within 60 cycles");
      return;
    end
    for (int i = 0; i < 42; i++) begin
      // Outputs trail the counters by two cycles, wrapping into the prior frame.
      j = (i + 40) % 42;
      e = expect_out(2, j % 7, j / 7);
      checks++;
      if (dx[2] !== 32'(i % 7) || dy[2] !== 32'(i / 7)) begin
        errors++;
        $display("FAIL small_seq_xy[%0d]: got X=%0d Y=%0d, expected X=%0d Y=%0d",
                 i, dx[2], dy[2], i % 7, i / 7);
      end
      checks++;
      if ({hs_v[2], vs_v[2], de_v[2]} !== {e.hs, e.vs, e.de}) begin
        errors++;
        $display("FAIL small_seq_sync[%0d]: got HS=%b VS=%b DE=%b, expected HS=%b VS=%b DE=%b",
                 i, hs_v[2], vs_v[2], de_v[2], e.hs, e.vs, e.de);
      end
      tick();
    end
    checks++;
    if (dx[2] !== 0 || dy[2] !== 0 || sof_v[2] !== 1'b1) begin
      errors++;
      $display("FAIL small_frame_wrap: got X=%0d Y=%0d SOF=%b, expected 0 0 1",
               dx[2], dy[2], sof_v[2]);
    end
  endtask

  task automatic test_mid_frame_reset();
    bit found;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (dx[0] == 300 && dy[0] >= 1 && dy[0] < 480) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_sync: X=300 inside active lines not reached");
      return;
    end
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    checks++;
    if (dx[0] !== 0 || dy[0] !== 0 || sof_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_restart: got X=%0d Y=%0d SOF=%b, expected 0 0 1",
               dx[0], dy[0], sof_v[0]);
    end
    checks++;
    if ({hs_v[0], vs_v[0], de_v[0]} !== 3'b110 || rgb_v[0] !== 24'h0) begin
      errors++;
      $display("FAIL midreset_flush1: got HS=%b VS=%b DE=%b RGB=%h, expected 1 1 0 000000",
               hs_v[0], vs_v[0], de_v[0], rgb_v[0]);
    end
    tick();
    checks++;
    if ({hs_v[0], vs_v[0], de_v[0]} !== 3'b110 || rgb_v[0] !== 24'h0) begin
      errors++;
      $display("FAIL midreset_flush2: got HS=%b VS=%b DE=%b RGB=%h, expected 1 1 0 000000",
               hs_v[0], vs_v[0], de_v[0], rgb_v[0]);
    end
    tick();
    checks++;
    if (de_v[0] !== 1'b1 || rgb_v[0] !== 24'h0000A5) begin
      errors++;
      $display("FAIL midreset_first_pixel: got DE=%b RGB=%h, expected 1 0000a5",
               de_v[0], rgb_v[0]);
    end
  endtask

  initial begin
    rst_v = '1;
    test_reset();
    test_line_timing("line");
    test_small_params();
    test_frame_timing(1, "mid_frame");
    test_frame_timing(2, "small_frame");
    test_mid_frame_reset();
    test_line_timing("line_after_reset");
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_vga_timing_gen
